// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment type and constants, segments {a,b,c,d,e,f,g} with a in bit 6.
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_ALL   = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0000001;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-high segment table; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = 7'b1111110;
      4'd1: o_seg = 7'b0110000;
      4'd2: o_seg = 7'b1101101;
      4'd3: o_seg = 7'b1111001;
      4'd4: o_seg = 7'b0110011;
      4'd5: o_seg = 7'b1011011;
      4'd6: o_seg = 7'b1011111;
      4'd7: o_seg = 7'b1110000;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1110011;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/display_mux_7seg.sv
// display_mux_7seg: scanned N-digit BCD display with tear-free shadow load, lamp test and blanking.
// Define DISPLAY_MUX_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module display_mux_7seg
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  load,
  input  logic                  lt,
  input  logic                  bi,
  output seg_t                  seg_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_tick
);
  localparam int SW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(N_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scan;
  logic [4*N_DIGITS-1:0] r_pending, r_active;
  logic r_pend_flag;
  logic w_adv, w_wrap, w_lz;
  logic [3:0] w_digit;
  seg_t w_dec, w_seg;
  logic [N_DIGITS-1:0] w_an;
  assign w_adv = r_pre == PRE_LAST;
  assign w_wrap = w_adv && r_scan == SCAN_LAST;
  assign w_digit = r_active[{r_scan, 2'b00} +: 4];
  seg7_decode u_dec (.i_bcd(w_digit), .o_seg(w_dec));
`ifdef DISPLAY_MUX_LZ_BLANK_EN
  logic [N_DIGITS-1:0] w_lz_mask;
  logic w_zero_run;
  // Walk down from the top digit; a digit is blanked while every digit above it is zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_mask = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      w_zero_run = w_zero_run && r_active[4*k +: 4] == 4'd0;
      w_lz_mask[k] = w_zero_run;
    end
  end
  assign w_lz = w_lz_mask[r_scan];
`else
  assign w_lz = 1'b0;
`endif
  assign w_seg = lt ? SEG_ALL : (!bi || w_lz) ? SEG_BLANK : w_dec;
  assign w_an = (!lt && !bi) ? '0 : AN_ONE << r_scan;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre       <= '0;
      r_scan      <= '0;
      r_pending   <= '0;
      r_active    <= '0;
      r_pend_flag <= 1'b0;
      seg_out     <= SEG_BLANK;
      an_out      <= '0;
      frame_tick  <= 1'b0;
    end else begin
      r_pre <= w_adv ? '0 : r_pre + 1'b1;
      if (w_adv) r_scan <= w_wrap ? '0 : r_scan + 1'b1;
      // Old pending value moves on the wrap; a same-cycle load stays pending for the next frame.
      if (w_wrap && r_pend_flag) r_active <= r_pending;
      if (load) r_pending <= bcd_in;
      r_pend_flag <= load || (r_pend_flag && !w_wrap);
      seg_out     <= w_seg;
      an_out      <= w_an;
      frame_tick  <= w_wrap;
    end
  end
endmodule

// File: tb/tb_display_mux_7seg.sv
// tb_display_mux_7seg: directed vectors and corner sequences for a 4-digit, 3-clock-slot display.
module tb_display_mux_7seg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic load = 1'b0;
  logic lt = 1'b0;
  logic bi = 1'b1;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic frame_tick;
  int checks = 0;
  int errors = 0;

  display_mux_7seg #(.N_DIGITS(4), .CLK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load), .lt(lt), .bi(bi),
    .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        lt;
    logic        bi;
    logic [27:0] seg;
    logic [15:0] an;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    check("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  // Called at the negedge where frame_tick is seen; digit k sampled 1+3k negedges later.
  task automatic sample_frame(input string name, input logic [27:0] seg, input logic [15:0] an);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (3) @(negedge clk);
      check($sformatf("%s_seg%0d", name, k), {25'd0, seg_out}, {25'd0, seg[7*k +: 7]});
      check($sformatf("%s_an%0d", name, k), {28'd0, an_out}, {28'd0, an[4*k +: 4]});
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 1'b1, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 16'h8421};
    vecs[4] = '{16'h5678, 1'b1, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 16'h8421};
    vecs[5] = '{16'h5678, 1'b0, 1'b0, 28'd0, 16'h0000};
    vecs[6] = '{16'h5678, 1'b0, 1'b1, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}, 16'h8421};
    vecs[7] = '{16'h0005, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 16'h8421};
`ifdef DISPLAY_MUX_LZ_BLANK_EN
    vecs[1] = '{16'h00A9, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000001, 7'b1110011}, 16'h8421};
    vecs[2] = '{16'h0070, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110}, 16'h8421};
    vecs[3] = '{16'h0000, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 16'h8421};
    vecs[8] = '{16'h0005, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1011011}, 16'h8421};
`else
    vecs[1] = '{16'h00A9, 1'b0, 1'b1, {7'b1111110, 7'b1111110, 7'b0000001, 7'b1110011}, 16'h8421};
    vecs[2] = '{16'h0070, 1'b0, 1'b1, {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110}, 16'h8421};
    vecs[3] = '{16'h0000, 1'b0, 1'b1, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 16'h8421};
    vecs[8] = '{16'h0005, 1'b0, 1'b1, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1011011}, 16'h8421};
`endif
    #12;
    check("rst_seg", {25'd0, seg_out}, 32'd0);
    check("rst_an", {28'd0, an_out}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_an", {28'd0, an_out}, 32'h1);
    check("first_seg", {25'd0, seg_out}, 32'b1111110);

    foreach (vecs[i]) begin
      wait_tick();
      bcd_in = vecs[i].bcd;
      lt = vecs[i].lt;
      bi = vecs[i].bi;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_tick();
      sample_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].an);
    end
    lt = 1'b0;
    bi = 1'b1;

    // Tear-free: load during digit-2 slot must not disturb the current frame.
    wait_tick();
    bcd_in = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_tick();
    @(negedge clk);
    check("tear_d0", {25'd0, seg_out}, 32'b0110011);
    repeat (3) @(negedge clk);
    check("tear_d1", {25'd0, seg_out}, 32'b1111001);
    repeat (3) @(negedge clk);
    check("tear_d2", {25'd0, seg_out}, 32'b1101101);
    bcd_in = 16'h5678;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    check("tear_d3_old", {25'd0, seg_out}, 32'b0110000);
    wait_tick();
    @(negedge clk);
    check("tear_new_d0", {25'd0, seg_out}, 32'b1111111);
    repeat (9) @(negedge clk);
    check("tear_new_d3", {25'd0, seg_out}, 32'b1011011);

    // Load landing on the wrap edge: old pending shows, new one waits a frame.
    wait_tick();
    repeat (3) @(negedge clk);
    bcd_in = 16'h0001;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    bcd_in = 16'h0002;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("wrap_load_tick", {31'd0, frame_tick}, 32'd1);
    @(negedge clk);
    check("wrap_load_old", {25'd0, seg_out}, 32'b0110000);
    check("tick_one_cycle", {31'd0, frame_tick}, 32'd0);
    wait_tick();
    @(negedge clk);
    check("wrap_load_new", {25'd0, seg_out}, 32'b1101101);

    // Priority and one-cycle latency of bi/lt.
    bi = 1'b0;
    @(negedge clk);
    check("bi_seg", {25'd0, seg_out}, 32'd0);
    check("bi_an", {28'd0, an_out}, 32'd0);
    lt = 1'b1;
    @(negedge clk);
    check("lt_seg", {25'd0, seg_out}, 32'h7f);
    check("lt_an_live", {31'd0, an_out != 4'd0}, 32'd1);
    lt = 1'b0;
    bi = 1'b1;

    // Reset mid-frame with a pending load.
    wait_tick();
    repeat (7) @(negedge clk);
    bcd_in = 16'h4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seg", {25'd0, seg_out}, 32'd0);
    check("mid_rst_an", {28'd0, an_out}, 32'd0);
    check("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_an", {28'd0, an_out}, 32'h1);
    check("post_rst_seg", {25'd0, seg_out}, 32'b1111110);
    wait_tick();
    @(negedge clk);
    check("pending_discarded", {25'd0, seg_out}, 32'b1111110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
